// File: rtl/adsr_pkg.sv
// Shared definitions for the polyphonic ADSR envelope generator.
package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A    = 3'd1,
        ST_H    = 3'd2,
        ST_D    = 3'd3,
        ST_S    = 3'd4,
        ST_R    = 3'd5
    } adsr_state_e;

endpackage

// File: rtl/adsr_channel.sv
// One ADSR envelope channel: level-gated FSM with saturating WIDTH+1-bit steps.
// Optional hold stage after attack is enabled by defining ADSR_HOLD_EN.
module adsr_channel
    import adsr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              trig,
    input  logic [WIDTH-1:0]  ai,
    input  logic [WIDTH-1:0]  di,
    input  logic [WIDTH-1:0]  s,
    input  logic [WIDTH-1:0]  ri,
`ifdef ADSR_HOLD_EN
    input  logic [HOLD_W-1:0] hold,
`endif
    output logic [WIDTH-1:0]  env,
    output logic              active
);

    localparam logic [WIDTH-1:0] MAX = '1;

    adsr_state_e      state, state_n;
    logic [WIDTH-1:0] env_n;
    logic [WIDTH:0]   add_a, sub_d, sub_r;
`ifdef ADSR_HOLD_EN
    logic [HOLD_W-1:0] cnt, cnt_n;
`endif

    // The extra top bit of each result is the carry/borrow flag.
    assign add_a = {1'b0, env} + {1'b0, ai};
    assign sub_d = {1'b0, env} - {1'b0, di};
    assign sub_r = {1'b0, env} - {1'b0, ri};

    always_comb begin
        state_n = state;
        env_n   = env;
`ifdef ADSR_HOLD_EN
        cnt_n   = cnt;
`endif
        case (state)
            ST_IDLE: if (trig) state_n = ST_A;
            ST_A: begin
                if (!trig) begin
                    state_n = ST_R;
                end else if (add_a[WIDTH] || add_a[WIDTH-1:0] == MAX || ai == '0) begin
                    env_n = MAX;
`ifdef ADSR_HOLD_EN
                    if (hold != '0) begin
                        state_n = ST_H;
                        cnt_n   = hold;
                    end else begin
                        state_n = ST_D;
                    end
`else
                    state_n = ST_D;
`endif
                end else begin
                    env_n = add_a[WIDTH-1:0];
                end
            end
`ifdef ADSR_HOLD_EN
            ST_H: begin
                if (!trig) begin
                    state_n = ST_R;
                    cnt_n   = '0;
                end else if (cnt <= HOLD_W'(1)) begin
                    state_n = ST_D;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - HOLD_W'(1);
                end
            end
`endif
            ST_D: begin
                if (!trig) begin
                    state_n = ST_R;
                end else if (sub_d[WIDTH] || sub_d[WIDTH-1:0] < s || di == '0) begin
                    env_n   = s;
                    state_n = ST_S;
                end else begin
                    env_n = sub_d[WIDTH-1:0];
                end
            end
            ST_S: begin
                if (!trig) state_n = ST_R;
                else       env_n   = s;
            end
            ST_R: begin
                if (trig) begin
                    state_n = ST_A;
                end else if (sub_r[WIDTH] || sub_r[WIDTH-1:0] == '0 || ri == '0) begin
                    env_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    env_n = sub_r[WIDTH-1:0];
                end
            end
            default: begin
                state_n = ST_IDLE;
                env_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            env    <= '0;
            active <= 1'b0;
`ifdef ADSR_HOLD_EN
            cnt    <= '0;
`endif
        end else if (ce) begin
            state  <= state_n;
            env    <= env_n;
            active <= (state_n != ST_IDLE);
`ifdef ADSR_HOLD_EN
            cnt    <= cnt_n;
`endif
        end
    end

endmodule

// File: rtl/adsr_poly.sv
// NCH independent ADSR envelope channels sharing rate/sustain inputs.
// Define ADSR_HOLD_EN to add the hold port and hold stage.
module adsr_poly
    import adsr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NCH    = 4,
    parameter int HOLD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic [NCH-1:0]       trig,
    input  logic [WIDTH-1:0]     ai,
    input  logic [WIDTH-1:0]     di,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     ri,
`ifdef ADSR_HOLD_EN
    input  logic [HOLD_W-1:0]    hold,
`endif
    output logic [NCH*WIDTH-1:0] envelope,
    output logic [NCH-1:0]       active
);

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        adsr_channel #(
            .WIDTH (WIDTH),
            .HOLD_W(HOLD_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .ce    (ce),
            .trig  (trig[n]),
            .ai    (ai),
            .di    (di),
            .s     (s),
            .ri    (ri),
`ifdef ADSR_HOLD_EN
            .hold  (hold),
`endif
            .env   (envelope[n*WIDTH +: WIDTH]),
            .active(active[n])
        );
    end

endmodule

// File: tb/tb_adsr_poly.sv
// Directed bench for adsr_poly (WIDTH=8, NCH=4); hold checks run when ADSR_HOLD_EN is defined.
module tb_adsr_poly;
    import adsr_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [3:0]  trig;
    logic [7:0]  ai, di, s, ri;
`ifdef ADSR_HOLD_EN
    logic [7:0]  hold;
`endif
    logic [31:0] envelope;
    logic [3:0]  active;
    logic [2:0]  st0, st1, st2, st3;

    int n_checks = 0;
    int n_errors = 0;

    adsr_poly #(.WIDTH(8), .NCH(4), .HOLD_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .trig    (trig),
        .ai      (ai),
        .di      (di),
        .s       (s),
        .ri      (ri),
`ifdef ADSR_HOLD_EN
        .hold    (hold),
`endif
        .envelope(envelope),
        .active  (active)
    );

    assign st0 = dut.g_ch[0].u_ch.state;
    assign st1 = dut.g_ch[1].u_ch.state;
    assign st2 = dut.g_ch[2].u_ch.state;
    assign st3 = dut.g_ch[3].u_ch.state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] env_of(input int n);
        return envelope[n*8 +: 8];
    endfunction

    initial begin
        rst_n = 1'b0; ce = 1'b1; trig = 4'b0000;
        ai = 8'h40; di = 8'h30; s = 8'h80; ri = 8'h50;
`ifdef ADSR_HOLD_EN
        hold = 8'd0;
`endif
        #12;
        check("rst_env", envelope, 32'h0);
        check("rst_active", {28'h0, active}, 32'h0);
        check("rst_state", st0, ST_IDLE);
        rst_n = 1'b1;
        step();
        check("idle_hold", env_of(0), 8'h00);

        // Attack on channel 0
        trig = 4'b0001;
        step(); check("atk_entry_st", st0, ST_A); check("atk_entry_env", env_of(0), 8'h00);
        check("atk_active", {28'h0, active}, 32'h1);
        step(); check("atk_40", env_of(0), 8'h40);
        step(); check("atk_80", env_of(0), 8'h80);
        step(); check("atk_c0", env_of(0), 8'hC0);
        step(); check("atk_ff", env_of(0), 8'hFF); check("atk_to_d", st0, ST_D);

        // Decay then sustain, with a live sustain change
        step(); check("dec_cf", env_of(0), 8'hCF);
        step(); check("dec_9f", env_of(0), 8'h9F);
        step(); check("dec_80", env_of(0), 8'h80); check("dec_to_s", st0, ST_S);
        s = 8'h90;
        step(); check("sus_live_90", env_of(0), 8'h90);
        s = 8'h80;
        step(); check("sus_back_80", env_of(0), 8'h80);

        // Release, then retrigger from R with channel 1 toggling alongside
        trig = 4'b0000;
        step(); check("rel_entry_st", st0, ST_R); check("rel_entry_env", env_of(0), 8'h80);
        step(); check("rel_30", env_of(0), 8'h30);
        trig = 4'b0011;
        step(); check("retrig_st", st0, ST_A); check("retrig_env", env_of(0), 8'h30);
        check("ch1_atk_entry", env_of(1), 8'h00);
        step(); check("retrig_70", env_of(0), 8'h70); check("ch1_40", env_of(1), 8'h40);
        trig = 4'b0001;
        step(); check("ch0_b0", env_of(0), 8'hB0); check("ch1_gate_low", st1, ST_R);
        check("ch1_rel_entry", env_of(1), 8'h40);

        // Clock enable low freezes everything
        ce = 1'b0;
        step(3);
        check("ce_freeze_ch0", env_of(0), 8'hB0);
        check("ce_freeze_ch1", env_of(1), 8'h40);
        check("ce_freeze_st1", st1, ST_R);
        ce = 1'b1;
        step(); check("ce_resume_f0", env_of(0), 8'hF0); check("ch1_rel_borrow", env_of(1), 8'h00);
        check("ch1_idle_active", {31'h0, active[1]}, 32'h0);
        step(); check("atk_carry_clamp", env_of(0), 8'hFF); check("atk_carry_to_d", st0, ST_D);

        // Full release of channel 0 down to idle via borrow
        trig = 4'b0000;
        step(); check("rel2_ff", env_of(0), 8'hFF);
        step(); check("rel2_af", env_of(0), 8'hAF);
        step(); check("rel2_5f", env_of(0), 8'h5F);
        step(); check("rel2_0f", env_of(0), 8'h0F);
        step(); check("rel2_zero", env_of(0), 8'h00); check("rel2_idle", st0, ST_IDLE);
        check("rel2_active", {28'h0, active}, 32'h0);

        // Zero rates on channel 2: ai=0 clamps, di=0 snaps to s, ri=0 snaps to 0
        ai = 8'h00; trig = 4'b0100;
        step(); check("ai0_entry", st2, ST_A);
        step(); check("ai0_max", env_of(2), 8'hFF); check("ai0_to_d", st2, ST_D);
        di = 8'h00;
        step(); check("di0_s", env_of(2), 8'h80); check("di0_to_s", st2, ST_S);
        ri = 8'h00; trig = 4'b0000;
        step(); check("ri0_entry", env_of(2), 8'h80);
        step(); check("ri0_zero", env_of(2), 8'h00); check("ri0_idle", st2, ST_IDLE);

        // Exact-boundary sums on channel 3: attack lands on MAX, release lands on 0
        ai = 8'h55; di = 8'h30; ri = 8'h55; trig = 4'b1000;
        step(); step(); check("ch3_55", env_of(3), 8'h55);
        step(); check("ch3_aa", env_of(3), 8'hAA);
        step(); check("ch3_eq_max", env_of(3), 8'hFF); check("ch3_to_d", st3, ST_D);
        trig = 4'b0000;
        step(); step(); check("ch3_rel_aa", env_of(3), 8'hAA);
        step(); check("ch3_rel_55", env_of(3), 8'h55);
        step(); check("ch3_rel_eq0", env_of(3), 8'h00); check("ch3_idle", st3, ST_IDLE);

        // Asynchronous reset mid-attack, asserted and released between edges
        ai = 8'h40; ri = 8'h50; trig = 4'b0001;
        step(2); check("pre_rst_40", env_of(0), 8'h40);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_env", envelope, 32'h0);
        check("async_rst_active", {28'h0, active}, 32'h0);
        check("async_rst_state", st0, ST_IDLE);
        #2 rst_n = 1'b1;
        step(); check("post_rst_st", st0, ST_A); check("post_rst_env", env_of(0), 8'h00);
        step(); check("post_rst_40", env_of(0), 8'h40);

`ifdef ADSR_HOLD_EN
        hold = 8'd3;
        step(); step();
        step(); check("hold_entry_env", env_of(0), 8'hFF); check("hold_entry_st", st0, ST_H);
        step(); check("hold_2_st", st0, ST_H); check("hold_2_env", env_of(0), 8'hFF);
        step(); check("hold_3_st", st0, ST_H);
        step(); check("hold_exit_st", st0, ST_D); check("hold_exit_env", env_of(0), 8'hFF);
        step(); check("hold_first_dec", env_of(0), 8'hCF);
        hold = 8'd0; ai = 8'h00; trig = 4'b0011;
        step(); step(); check("hold0_to_d", st1, ST_D); check("hold0_env", env_of(1), 8'hFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
